// File: rtl/if_stage_pkg.sv
// Shared constants and helpers for the instruction-fetch stage.
// Optional build macro used by if_stage: IF_PC_ALIGN_CHECK_EN.
package if_stage_pkg;
  localparam logic [31:0] RESET_PC_VALUE = 32'hBFC0_0000;
  localparam int EXC_ADEL_IF    = 0;
  localparam int EXCEP_TYPE_BUS = 6;
  localparam int INST_ADDR_BUS  = 32;
  localparam int INST_BUS       = 32;
  localparam logic RST_ENABLE   = 1'b1;
  localparam logic EXCEPTION_ON = 1'b1;
  localparam logic NOSTOP       = 1'b0;

  // Sequential PC increment; wraps modulo 2^32.
  function automatic logic [INST_ADDR_BUS-1:0] pc_plus4(input logic [INST_ADDR_BUS-1:0] pc);
    return pc + 32'd4;
  endfunction
endpackage

// File: rtl/if_stage_pc_next_sel.sv
// Next-PC priority mux: reset > exception > branch on acceptance > pc+4 on acceptance > hold.
module pc_next_sel
  import if_stage_pkg::*;
(
  input  logic                     rst,
  input  logic [INST_ADDR_BUS-1:0] reset_pc,
  input  logic                     exception,
  input  logic [INST_ADDR_BUS-1:0] exception_pc,
  input  logic                     advance,
  input  logic                     br_take,
  input  logic [INST_ADDR_BUS-1:0] br_addr,
  input  logic [INST_ADDR_BUS-1:0] pc,
  output logic [INST_ADDR_BUS-1:0] pc_next
);
  always_comb begin
    pc_next = pc;
    if (rst == RST_ENABLE)             pc_next = reset_pc;
    else if (exception == EXCEPTION_ON) pc_next = exception_pc;
    else if (advance && br_take)       pc_next = br_addr;
    else if (advance)                  pc_next = pc_plus4(pc);
  end
endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: PC register, fetch bus FSM, branch delay slot and redirects.
// Build macro IF_PC_ALIGN_CHECK_EN enables the misaligned-PC fetch exception.
module if_stage
  import if_stage_pkg::*;
#(
  parameter logic [INST_ADDR_BUS-1:0] RESET_PC = RESET_PC_VALUE
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      stall,
  input  logic                      exception,
  input  logic [INST_ADDR_BUS-1:0]  exception_pc,
  input  logic                      branch_en,
  input  logic [INST_ADDR_BUS-1:0]  branch_target,
  output logic                      inst_req,
  output logic [INST_ADDR_BUS-1:0]  inst_addr,
  input  logic                      inst_addr_ok,
  input  logic                      inst_data_ok,
  input  logic [INST_BUS-1:0]       inst_rdata,
  output logic [INST_ADDR_BUS-1:0]  if_pc,
  output logic [INST_BUS-1:0]       if_instr,
  output logic [EXCEP_TYPE_BUS-1:0] if_exception_type,
  output logic                      inst_stall
);
  // Bus handshake: a request is accepted in the cycle inst_req && inst_addr_ok;
  // its data returns in a later cycle flagged by inst_data_ok, one outstanding max.
  typedef enum logic [1:0] {S_REQ, S_WAIT, S_HOLD, S_DROP} state_t;

  state_t                    state;
  logic [INST_ADDR_BUS-1:0]  pc;
  logic [INST_ADDR_BUS-1:0]  pc_next;
  logic [INST_ADDR_BUS-1:0]  br_target;
  logic [INST_BUS-1:0]       hold_buf;
  logic                      br_pending;
  logic                      inst_valid;
  logic                      align_fault;
  logic                      accept;
  logic                      br_take;
  logic [INST_ADDR_BUS-1:0]  br_addr;

  assign inst_valid = (rst != RST_ENABLE) && (exception != EXCEPTION_ON) &&
                      ((state == S_WAIT && inst_data_ok) || state == S_HOLD);
`ifdef IF_PC_ALIGN_CHECK_EN
  // A misaligned PC parks in S_REQ, presenting the fault until the exception unit redirects.
  assign align_fault = (rst != RST_ENABLE) && (exception != EXCEPTION_ON) &&
                       state == S_REQ && pc[1:0] != 2'b00;
  assign inst_addr   = (rst == RST_ENABLE) ? '0 : pc;
`else
  assign align_fault = 1'b0;
  assign inst_addr   = (rst == RST_ENABLE) ? '0 : {pc[INST_ADDR_BUS-1:2], 2'b00};
`endif
  assign accept     = inst_valid && (stall == NOSTOP);
  // A pending branch is older than one resolving now, so it wins the delay-slot acceptance.
  assign br_take    = br_pending || branch_en;
  assign br_addr    = br_pending ? br_target : branch_target;
  assign inst_req   = (rst != RST_ENABLE) && state == S_REQ && !align_fault;
  assign inst_stall = !(inst_valid || align_fault);
  assign if_pc      = inst_stall ? '0 : pc;
  assign if_instr   = !inst_valid ? '0 : (state == S_HOLD) ? hold_buf : inst_rdata;

  always_comb begin
    if_exception_type = '0;
    if_exception_type[EXC_ADEL_IF] = align_fault;
  end

  pc_next_sel u_pc_next_sel (
    .rst          (rst),
    .reset_pc     (RESET_PC),
    .exception    (exception),
    .exception_pc (exception_pc),
    .advance      (accept),
    .br_take      (br_take),
    .br_addr      (br_addr),
    .pc           (pc),
    .pc_next      (pc_next)
  );

  always_ff @(posedge clk) begin
    pc <= pc_next;
    if (rst == RST_ENABLE) begin
      state      <= S_REQ;
      br_pending <= 1'b0;
      br_target  <= '0;
      hold_buf   <= '0;
    end else if (exception == EXCEPTION_ON) begin
      br_pending <= 1'b0;
      unique case (state)
        S_REQ:   state <= (inst_req && inst_addr_ok) ? S_DROP : S_REQ;
        S_HOLD:  state <= S_REQ;
        default: state <= inst_data_ok ? S_REQ : S_DROP;
      endcase
    end else begin
      if (accept) begin
        br_pending <= br_pending && branch_en;
        if (branch_en) br_target <= branch_target;
      end else if (branch_en) begin
        br_pending <= 1'b1;
        br_target  <= branch_target;
      end
      unique case (state)
        S_REQ:  if (inst_req && inst_addr_ok) state <= S_WAIT;
        S_WAIT: begin
          if (inst_data_ok) begin
            if (accept) begin
              state <= S_REQ;
            end else begin
              hold_buf <= inst_rdata;
              state    <= S_HOLD;
            end
          end
        end
        S_HOLD: if (accept) state <= S_REQ;
        S_DROP: if (inst_data_ok) state <= S_REQ;
        default: state <= S_REQ;
      endcase
    end
  end
endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: fetch sequence, stall hold, branch delay slot, redirects, reset.
module tb_if_stage;
  logic        clk = 1'b0;
  logic        rst, stall, exception, branch_en;
  logic [31:0] exception_pc, branch_target;
  logic        inst_req, inst_addr_ok, inst_data_ok, inst_stall;
  logic [31:0] inst_addr, inst_rdata, if_pc, if_instr;
  logic [5:0]  if_exception_type;
  int          checks = 0;
  int          errors = 0;

  if_stage dut (
    .clk(clk), .rst(rst), .stall(stall), .exception(exception),
    .exception_pc(exception_pc), .branch_en(branch_en), .branch_target(branch_target),
    .inst_req(inst_req), .inst_addr(inst_addr), .inst_addr_ok(inst_addr_ok),
    .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata), .if_pc(if_pc),
    .if_instr(if_instr), .if_exception_type(if_exception_type), .inst_stall(inst_stall)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs change 1ns after the edge, pulses default low.
  task automatic step();
    @(posedge clk);
    #1;
    inst_addr_ok = 1'b0; inst_data_ok = 1'b0; branch_en = 1'b0;
    exception = 1'b0; stall = 1'b0;
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; exception = 1'b0; branch_en = 1'b0;
    exception_pc = '0; branch_target = '0;
    inst_addr_ok = 1'b0; inst_data_ok = 1'b0; inst_rdata = '0;
    step(); step();
    #1;
    check("rst_req", {31'b0, inst_req}, 32'd0);
    check("rst_stall", {31'b0, inst_stall}, 32'd1);
    check("rst_addr", inst_addr, 32'd0);
    check("rst_if_pc", if_pc, 32'd0);

    step(); rst = 1'b0; #1;
    check("f0_req", {31'b0, inst_req}, 32'd1);
    check("f0_addr", inst_addr, 32'hBFC00000);
    inst_addr_ok = 1'b1;
    step(); inst_data_ok = 1'b1; inst_rdata = 32'h11112222; #1;
    check("f0_req_wait", {31'b0, inst_req}, 32'd0);
    check("f0_stall", {31'b0, inst_stall}, 32'd0);
    check("f0_if_pc", if_pc, 32'hBFC00000);
    check("f0_instr", if_instr, 32'h11112222);
    step(); #1;
    check("f1_addr", inst_addr, 32'hBFC00004);
    check("f1_req", {31'b0, inst_req}, 32'd1);
    check("f1_idle_stall", {31'b0, inst_stall}, 32'd1);
    inst_addr_ok = 1'b1;

    // stall held over three cycles starting at data_ok
    step(); inst_data_ok = 1'b1; inst_rdata = 32'h24010001; stall = 1'b1; #1;
    check("st_if_pc", if_pc, 32'hBFC00004);
    check("st_instr0", if_instr, 32'h24010001);
    step(); stall = 1'b1; inst_rdata = 32'hDEADBEEF; #1;
    check("st_hold_req", {31'b0, inst_req}, 32'd0);
    check("st_hold_instr", if_instr, 32'h24010001);
    check("st_hold_stall", {31'b0, inst_stall}, 32'd0);
    step(); stall = 1'b1; #1;
    check("st_hold2_req", {31'b0, inst_req}, 32'd0);
    step(); #1;
    check("st_rel_instr", if_instr, 32'h24010001);
    check("st_rel_pc", if_pc, 32'hBFC00004);
    step(); #1;
    check("f2_addr", inst_addr, 32'hBFC00008);

    // branch latched while fetching BFC00008; that instruction is the delay slot
    inst_addr_ok = 1'b1; branch_en = 1'b1; branch_target = 32'hBFC00100;
    step(); inst_data_ok = 1'b1; inst_rdata = 32'h00000000; #1;
    check("br_slot_pc", if_pc, 32'hBFC00008);
    step(); #1;
    check("br_addr", inst_addr, 32'hBFC00100);
    inst_addr_ok = 1'b1;
    // branch coinciding with acceptance applies at once
    step(); inst_data_ok = 1'b1; branch_en = 1'b1; branch_target = 32'hBFC00200; #1;
    check("brc_pc", if_pc, 32'hBFC00100);
    step(); #1;
    check("brc_addr", inst_addr, 32'hBFC00200);

    // exception in S_WAIT drops the outstanding response
    inst_addr_ok = 1'b1;
    step(); exception = 1'b1; exception_pc = 32'hBFC00380; #1;
    check("exc_stall", {31'b0, inst_stall}, 32'd1);
    check("exc_if_pc", if_pc, 32'd0);
    step(); #1;
    check("drop_req", {31'b0, inst_req}, 32'd0);
    step(); inst_data_ok = 1'b1; inst_rdata = 32'hCAFEF00D; #1;
    check("drop_stall", {31'b0, inst_stall}, 32'd1);
    check("drop_instr", if_instr, 32'd0);
    step(); #1;
    check("exc_addr", inst_addr, 32'hBFC00380);
    check("exc_req", {31'b0, inst_req}, 32'd1);

    // reset in the middle of a transaction
    inst_addr_ok = 1'b1;
    step(); rst = 1'b1; inst_rdata = 32'h12345678; #1;
    check("rstw_req", {31'b0, inst_req}, 32'd0);
    check("rstw_stall", {31'b0, inst_stall}, 32'd1);
    check("rstw_instr", if_instr, 32'd0);
    step(); rst = 1'b0; #1;
    check("rstw_addr", inst_addr, 32'hBFC00000);
    check("rstw_req1", {31'b0, inst_req}, 32'd1);

    // exception in S_REQ with same-cycle addr_ok leaves a response to drop; PC wraps
    exception = 1'b1; exception_pc = 32'hFFFFFFFC; inst_addr_ok = 1'b1; #1;
    check("excr_stall", {31'b0, inst_stall}, 32'd1);
    step(); #1;
    check("excr_drop_req", {31'b0, inst_req}, 32'd0);
    inst_data_ok = 1'b1;
    step(); #1;
    check("excr_addr", inst_addr, 32'hFFFFFFFC);
    inst_addr_ok = 1'b1;
    step(); inst_data_ok = 1'b1; #1;
    check("wrap_if_pc", if_pc, 32'hFFFFFFFC);
    step(); #1;
    check("wrap_addr", inst_addr, 32'h00000000);

    // branch to a misaligned target
    inst_addr_ok = 1'b1; branch_en = 1'b1; branch_target = 32'hBFC00102;
    step(); inst_data_ok = 1'b1; #1;
    check("mis_slot_pc", if_pc, 32'h00000000);
    step(); #1;
`ifdef IF_PC_ALIGN_CHECK_EN
    check("mis_req", {31'b0, inst_req}, 32'd0);
    check("mis_stall", {31'b0, inst_stall}, 32'd0);
    check("mis_if_pc", if_pc, 32'hBFC00102);
    check("mis_exc", {26'b0, if_exception_type}, 32'h01);
    check("mis_instr", if_instr, 32'd0);
    step(); exception = 1'b1; exception_pc = 32'hBFC00380; #1;
    check("mis_exc_stall", {31'b0, inst_stall}, 32'd1);
    step(); #1;
    check("mis_redir_addr", inst_addr, 32'hBFC00380);
    check("mis_redir_exc", {26'b0, if_exception_type}, 32'd0);
`else
    check("mis_req", {31'b0, inst_req}, 32'd1);
    check("mis_addr", inst_addr, 32'hBFC00100);
    check("mis_exc", {26'b0, if_exception_type}, 32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
